// File: rtl/spi_dev_resp_src.sv
// SPI device response source: byte FIFO with frame counter that
// requests the arbiter and streams each buffered frame as rdata/rstb.
module spi_dev_resp_src #(
  parameter int DEPTH = 16,
  parameter int GAP   = 0,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    wr_data,
  input  logic          wr_last,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic          resp_req,
  input  logic          resp_gnt,
  output logic [7:0]    resp_rdata,
  output logic          resp_rstb,
  output logic [AW:0]   level,
  output logic [AW:0]   frames
);

  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    REL
  } state_t;

  state_t          state, state_n;
  logic [8:0]      mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [GW-1:0]   gap_cnt;
  logic [8:0]      head;
  logic            flush;
  logic            push, pop;
  logic            burst_end;
  logic            req_n;

  assign head     = mem[rptr];
  assign wr_ready = (level != (AW+1)'(DEPTH));
  assign push     = wr_valid & wr_ready;

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    burst_end = 1'b0;
    unique case (state)
      IDLE: if (frames != '0 || flush) state_n = REQ;
      REQ:  if (resp_gnt) state_n = XFER;
      XFER: begin
        pop = resp_gnt && (gap_cnt == '0) && (level != '0);
        // a flush burst ends once the FIFO actually runs dry
        burst_end = pop && (head[8] ||
          (flush && level == (AW+1)'(1) && !push));
        if (burst_end) state_n = REL;
      end
      REL:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    req_n = (state_n == REQ) || (state_n == XFER);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {wr_last, wr_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_req   <= 1'b0;
      resp_rstb  <= 1'b0;
      resp_rdata <= '0;
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      frames     <= '0;
      flush      <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      state     <= state_n;
      resp_req  <= req_n;
      resp_rstb <= pop;
      if (pop) resp_rdata <= head[7:0];
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (push && !pop) level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      if ((push && wr_last) && !(pop && head[8]))
        frames <= frames + 1'b1;
      else if ((pop && head[8]) && !(push && wr_last))
        frames <= frames - 1'b1;
      // an unterminated frame filling the FIFO would never be sent
      if (burst_end) flush <= 1'b0;
      else if (level == (AW+1)'(DEPTH) && frames == '0)
        flush <= 1'b1;
      if (state != XFER) gap_cnt <= '0;
      else if (pop) gap_cnt <= GW'(GAP);
      else if (resp_gnt && gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule
